// File: rtl/afifo_wr_packer.sv
// Write-side packer for the async FIFO: packs RATIO narrow lanes into one wide
// FIFO word {eop, cnt, lanes}, flushing short words on end-of-packet or idle timeout.
module afifo_wr_packer #(
  parameter int unsigned IWIDTH  = 8,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned TIMEOUT = 0,
  localparam int unsigned CW     = $clog2(RATIO),
  localparam int unsigned FWIDTH = IWIDTH * RATIO + CW + 1
) (
  input  logic              wr_rst,
  input  logic              wr_clk,
  input  logic [IWIDTH-1:0] i_dat,
  input  logic              i_val,
  input  logic              i_eop,
  output logic              i_rdy,
  output logic [FWIDTH-1:0] fifo_data,
  output logic              fifo_req,
  input  logic              fifo_full
);

  localparam int unsigned AW  = IWIDTH * RATIO;
  localparam int unsigned IDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  LAST_LANE = CW'(RATIO - 1);
  localparam logic [IDW-1:0] IDLE_MAX  = IDW'(TIMEOUT);

  logic [AW-1:0]     asm_q, asm_d;
  logic [CW-1:0]     lane_q, lane_d;
  logic [IDW-1:0]    idle_q, idle_d;
  logic              out_vld_q, out_vld_d;
  logic [FWIDTH-1:0] out_q, out_d;
  logic              room;
  logic              acc;
  logic              load;
  logic [AW-1:0]     merged;

  // Output register can take a new word when empty or draining this cycle.
  assign room      = ~out_vld_q | ~fifo_full;
  assign i_rdy     = ~wr_rst & room;
  assign fifo_req  = out_vld_q & ~fifo_full;
  assign fifo_data = out_q;
  assign acc       = i_val & i_rdy;

  // Next-state: lane assembly, idle timeout flush, output register load/drain.
  always_comb begin
    asm_d     = asm_q;
    lane_d    = lane_q;
    idle_d    = idle_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    load      = 1'b0;
    merged    = asm_q;
    merged[lane_q * IWIDTH +: IWIDTH] = i_dat;

    if (acc) begin
      idle_d = '0;
      if (lane_q == LAST_LANE || i_eop) begin
        load   = 1'b1;
        out_d  = {i_eop, lane_q, merged};
        asm_d  = '0;
        lane_d = '0;
      end else begin
        asm_d  = merged;
        lane_d = lane_q + CW'(1);
      end
    end else if (TIMEOUT > 0 && lane_q != '0) begin
      if (idle_q == IDLE_MAX) begin
        // Expired: flush once the output register is free, else hold saturated.
        if (room) begin
          load   = 1'b1;
          out_d  = {1'b0, lane_q - CW'(1), asm_q};
          asm_d  = '0;
          lane_d = '0;
          idle_d = '0;
        end
      end else begin
        idle_d = idle_q + IDW'(1);
      end
    end else begin
      idle_d = '0;
    end

    if (load) begin
      out_vld_d = 1'b1;
    end else if (fifo_req) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      asm_q     <= '0;
      lane_q    <= '0;
      idle_q    <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      asm_q     <= asm_d;
      lane_q    <= lane_d;
      idle_q    <= idle_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

endmodule

// File: tb/tb_afifo_wr_packer.sv
// Bench for afifo_wr_packer: queue-based packing model checked every cycle,
// plus literal checks of the written words and their timing.
module tb_afifo_wr_packer;

  localparam int unsigned IWIDTH  = 8;
  localparam int unsigned RATIO   = 4;
  localparam int unsigned TIMEOUT = 5;
  localparam int unsigned CW      = 2;
  localparam int unsigned LW      = IWIDTH * RATIO;
  localparam int unsigned FWIDTH  = LW + CW + 1;

  logic              wr_rst;
  logic              wr_clk;
  logic [IWIDTH-1:0] i_dat;
  logic              i_val;
  logic              i_eop;
  logic              i_rdy;
  logic [FWIDTH-1:0] fifo_data;
  logic              fifo_req;
  logic              fifo_full;

  afifo_wr_packer #(.IWIDTH(IWIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
    .wr_rst    (wr_rst),
    .wr_clk    (wr_clk),
    .i_dat     (i_dat),
    .i_val     (i_val),
    .i_eop     (i_eop),
    .i_rdy     (i_rdy),
    .fifo_data (fifo_data),
    .fifo_req  (fifo_req),
    .fifo_full (fifo_full)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_t  = 0;

  // Model: pending lanes as a queue, one output slot, idle cycle count.
  logic [IWIDTH-1:0] part[$];
  logic              m_vld;
  logic [FWIDTH-1:0] m_word;
  int                m_idle;

  logic [FWIDTH-1:0] got_w[$];
  int                got_t[$];
  logic [IWIDTH-1:0] sent[$];

  logic              exp_rdy, exp_req, m_acc, m_load;
  logic [FWIDTH-1:0] nw;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word made from the pending lanes: cnt is the number of lanes filled minus one.
  task automatic build(input logic eop, output logic [FWIDTH-1:0] w);
    w = '0;
    for (int k = 0; k < part.size(); k++) w[IWIDTH*k +: IWIDTH] = part[k];
    w[LW +: CW]    = CW'(part.size() - 1);
    w[FWIDTH-1]    = eop;
    part.delete();
  endtask

  always @(negedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      part.delete();
      m_vld  = 1'b0;
      m_word = '0;
      m_idle = 0;
    end else begin
      exp_rdy = !m_vld || !fifo_full;
      exp_req = m_vld && !fifo_full;
      chk("i_rdy", 64'(i_rdy), 64'(exp_rdy));
      chk("fifo_req", 64'(fifo_req), 64'(exp_req));
      if (m_vld) chk("fifo_data", 64'(fifo_data), 64'(m_word));
      if (fifo_req) begin
        got_w.push_back(fifo_data);
        got_t.push_back(cyc);
      end
      m_acc  = i_val && exp_rdy;
      m_load = 1'b0;
      if (m_acc) begin
        part.push_back(i_dat);
        m_idle = 0;
        acc_t  = cyc;
        if (part.size() == RATIO || i_eop) begin
          build(i_eop, nw);
          m_load = 1'b1;
        end
      end else if (part.size() == 0) begin
        m_idle = 0;
      end else if (m_idle == TIMEOUT) begin
        if (exp_rdy) begin
          build(1'b0, nw);
          m_idle = 0;
          m_load = 1'b1;
        end
      end else begin
        m_idle++;
      end
      if (m_load) begin
        m_vld  = 1'b1;
        m_word = nw;
      end else if (exp_req) begin
        m_vld = 1'b0;
      end
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic send(input logic [IWIDTH-1:0] d, input logic e);
    int n;
    n = 0;
    i_val = 1'b1;
    i_dat = d;
    i_eop = e;
    forever begin
      @(negedge wr_clk);
      if (i_rdy) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_wait: lane %0h not accepted within 100 cycles", d);
        break;
      end
      @(posedge wr_clk);
      #1;
    end
    @(posedge wr_clk);
    #1;
    i_val = 1'b0;
    i_eop = 1'b0;
  endtask

  // Rebuild the lane stream from written words and compare with what was sent.
  task automatic check_stream(input string name);
    logic [IWIDTH-1:0] outl[$];
    logic [FWIDTH-1:0] w;
    int c;
    for (int i = 0; i < got_w.size(); i++) begin
      w = got_w[i];
      c = int'(w[LW +: CW]);
      for (int k = 0; k <= c; k++) outl.push_back(w[IWIDTH*k +: IWIDTH]);
    end
    chk({name, "_len"}, 64'(outl.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size() && i < outl.size(); i++)
      chk({name, "_lane"}, 64'(outl[i]), 64'(sent[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stop;
    int t0;
    wr_rst = 1'b1; i_val = 1'b0; i_dat = '0; i_eop = 1'b0; fifo_full = 1'b0;
    #1;
    chk("rst_fifo_req", 64'(fifo_req), 64'd0);
    chk("rst_i_rdy", 64'(i_rdy), 64'd0);
    chk("rst_fifo_data", 64'(fifo_data), 64'd0);
    repeat (3) @(posedge wr_clk);
    #2 wr_rst = 1'b0;
    tick(1);
    chk("rdy_after_rst", 64'(i_rdy), 64'd1);

    // Full word of four lanes
    got_w.delete(); got_t.delete();
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0);
    tick(3);
    chk("full_word_count", 64'(got_w.size()), 64'd1);
    if (got_w.size() == 1) begin
      chk("full_word_data", 64'(got_w[0]), 64'({1'b0, 2'd3, 32'h04030201}));
      chk("full_word_lat", 64'(got_t[0]), 64'(acc_t + 1));
    end

    // Short packet ended by eop
    got_w.delete(); got_t.delete();
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b1);
    tick(3);
    chk("eop_count", 64'(got_w.size()), 64'd1);
    if (got_w.size() == 1) chk("eop_data", 64'(got_w[0]), 64'({1'b1, 2'd1, 32'h00000B0A}));

    // Back-pressure on a loaded word
    got_w.delete(); got_t.delete();
    fifo_full = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_req", 64'(fifo_req), 64'd0);
      chk("bp_rdy", 64'(i_rdy), 64'd0);
      chk("bp_data", 64'(fifo_data), 64'({1'b0, 2'd3, 32'h44332211}));
      tick(1);
    end
    fifo_full = 1'b0;
    #1;
    chk("bp_release_req", 64'(fifo_req), 64'd1);
    chk("bp_release_rdy", 64'(i_rdy), 64'd1);
    tick(3);
    chk("bp_count", 64'(got_w.size()), 64'd1);

    // Idle timeout flush of a single lane
    got_w.delete(); got_t.delete();
    send(8'h11, 1'b0);
    tick(10);
    chk("to_count", 64'(got_w.size()), 64'd1);
    if (got_w.size() == 1) begin
      chk("to_data", 64'(got_w[0]), 64'({1'b0, 2'd0, 32'h00000011}));
      chk("to_lat", 64'(got_t[0]), 64'(acc_t + 7));
    end

    // Accept exactly in the expiry cycle: no flush then, later flush of both lanes
    got_w.delete(); got_t.delete();
    send(8'h33, 1'b0);
    tick(5);
    send(8'h22, 1'b0);
    tick(12);
    chk("to_acc_count", 64'(got_w.size()), 64'd1);
    if (got_w.size() == 1) begin
      chk("to_acc_data", 64'(got_w[0]), 64'({1'b0, 2'd1, 32'h00002233}));
      chk("to_acc_lat", 64'(got_t[0]), 64'(acc_t + 7));
    end

    // Asynchronous reset mid-word
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
    #1 wr_rst = 1'b1;
    #1;
    chk("arst_req", 64'(fifo_req), 64'd0);
    chk("arst_rdy", 64'(i_rdy), 64'd0);
    #1 wr_rst = 1'b0;
    tick(1);
    got_w.delete(); got_t.delete();
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
    tick(3);
    chk("arst_count", 64'(got_w.size()), 64'd1);
    if (got_w.size() == 1) chk("arst_data", 64'(got_w[0]), 64'({1'b0, 2'd3, 32'hA4A3A2A1}));

    // 16-lane stream, no back-pressure: one write every 4 cycles
    got_w.delete(); got_t.delete(); sent.delete();
    for (int i = 0; i < 16; i++) begin
      sent.push_back(8'($urandom));
      send(sent[i], 1'b0);
    end
    tick(3);
    chk("stream_count", 64'(got_w.size()), 64'd4);
    for (int i = 1; i < got_w.size(); i++) chk("stream_gap", 64'(got_t[i] - got_t[i-1]), 64'd4);
    check_stream("stream");

    // 16-lane stream with random fifo_full pulses
    got_w.delete(); got_t.delete(); sent.delete();
    for (int i = 0; i < 16; i++) sent.push_back(8'($urandom));
    stop = 1'b0;
    t0 = cyc;
    fork
      begin
        for (int i = 0; i < 16; i++) send(sent[i], 1'b0);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          fifo_full = ($urandom_range(0, 3) == 0);
          tick(1);
        end
        fifo_full = 1'b0;
      end
    join
    tick(12);
    check_stream("bp_stream");
    chk("bp_stream_ran", 64'(cyc > t0 + 16), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afifo_wr_packer.md
# afifo_wr_packer

Write-side adapter for the asynchronous FIFO, in the wr_clk domain. It accepts a narrow valid/ready stream and packs RATIO input words into one wide FIFO word. It flushes short words on end-of-packet or on idle timeout, and drives the FIFO write port (wr_data/wr_req) while honouring the FIFO's wr_full. The matching read-side unpacker lives at the other end of the FIFO.

## Interface
Parameters:
- IWIDTH, 8, input lane width (IWIDTH > 0)
- RATIO, 4, lanes per FIFO word; power of two, RATIO ≥ 2
- TIMEOUT, 0, idle cycles before a partial word is flushed; 0 disables the timeout
- Derived: CW = $clog2(RATIO); FWIDTH = IWIDTH*RATIO + CW + 1

Ports:
- wr_rst  in  1  reset, asynchronous, active-high
- wr_clk  in  1  clock
- i_dat  in  IWIDTH  input lane data
- i_val  in  1  input valid
- i_eop  in  1  last lane of packet; qualified by i_val
- i_rdy  out  1  input ready
- fifo_data  out  FWIDTH  packed word {eop, cnt[CW-1:0], lanes[IWIDTH*RATIO-1:0]}
- fifo_req  out  1  FIFO write request
- fifo_full  in  1  FIFO full flag (wr_full)

## Operation
- Accept: acc = i_val & i_rdy.
- i_rdy = ~wr_rst & (~out_vld | ~fifo_full).
- Write: fifo_req = out_vld & ~fifo_full. A word is consumed exactly on a cycle with fifo_req = 1.
- Assembly register asm[IWIDTH*RATIO-1:0] with lane index lane[CW-1:0].
  - Lane k occupies bits [k*IWIDTH +: IWIDTH]; lane 0 is in the LSBs.
- On acc, i_dat goes into lane `lane`. The word completes if lane == RATIO-1 or i_eop = 1.
  - Complete: load the output register with the assembled lanes including i_dat, unfilled lanes zero, cnt = lane, eop = i_eop. Set out_vld, clear asm to 0 and set lane to 0.
  - Not complete: lane increments.
- Output register: out_vld is cleared on a write unless it is reloaded in the same cycle. Load and drain in the same cycle are legal; the new word replaces the old one.
- Timeout (TIMEOUT > 0), idle counter idle:
  - Cleared on acc and whenever lane == 0.
  - Otherwise increments while lane != 0, saturating at TIMEOUT.
  - When idle == TIMEOUT and (~out_vld | ~fifo_full), the partial word is flushed: load the output register with cnt = lane-1, eop = 0. Then clear asm, lane and idle.
  - If the output register is busy, the flush waits; idle stays saturated.
  - acc in the expiry cycle takes precedence: the lane is appended and idle is cleared. No flush occurs that cycle.
- A packet whose length is a multiple of RATIO ends with cnt = RATIO-1, eop = 1. No empty trailer word is produced.
- Reset (asynchronous, any time) discards any partial word and any pending output word.

## Timing
- Reset values: fifo_req = 0, fifo_data = 0, i_rdy = 0 while wr_rst is high. Internally out_vld = 0, lane = 0, idle = 0, asm = 0.
- i_rdy = 1 from the first cycle after reset deassertion.
- Latency: the word completes on a cycle-N accept. fifo_data is valid from cycle N+1, and fifo_req is high in N+1 if fifo_full = 0.
- Throughput: one lane per cycle sustained while fifo_full = 0; no bubbles at word boundaries.
- fifo_full = 1 with out_vld:
  - fifo_req = 0; fifo_data stays stable; i_rdy = 0.
  - The partial asm is untouched.
  - Resumes the first cycle fifo_full = 0.
- fifo_full = 1 without out_vld: i_rdy stays 1, and at most one word can complete into the output register.
- i_rdy and fifo_req are combinational from fifo_full (registered in the FIFO). There is no path from i_val to i_rdy.
- Timeout flush:
  - Last accept on cycle N, then idle. idle reaches TIMEOUT at the end of cycle N+TIMEOUT.
  - The flush load happens in cycle N+TIMEOUT+1, and fifo_req is high in cycle N+TIMEOUT+2.

## Test plan
- IWIDTH=8, RATIO=4, fifo_full=0:
  - Stimulus: accept 01,02,03,04 on consecutive cycles, i_eop=0.
  - Required: a single fifo_req pulse one cycle after 04, with fifo_data = {1'b0, 2'd3, 32'h04030201}.
- Accept 0A, then 0B with i_eop=1 -> fifo_data = {1'b1, 2'd1, 32'h00000B0A}, and lane returns to 0.
- Back-pressure:
  - Load a full word, hold fifo_full=1 for 10 cycles: fifo_req=0, i_rdy=0, fifo_data stable.
  - Drop fifo_full: exactly one write, and i_rdy=1 in the same cycle.
- TIMEOUT=5:
  - Accept 11, then idle -> fifo_req high 7 cycles after the accept, fifo_data = {1'b0, 2'd0, 32'h00000011}.
  - Repeat with an accept 22 in the expiry cycle -> no flush occurs that cycle.
- Reset mid-word:
  - Accept 3 lanes, pulse wr_rst asynchronously (no clock edge) -> fifo_req=0 and i_rdy=0 immediately.
  - Then accept A1..A4 -> a single word with value 32'hA4A3A2A1.
- Stream 16 lanes back-to-back with random fifo_full pulses:
  - Concatenating the written words reproduces the input order exactly, with no loss or duplication.
  - With fifo_full=0 throughout: one write every 4 cycles and i_rdy stays 1.
